prbs_sequence_checker: RTL and testbench

- Receive-side partner of the 4-bit Fibonacci LFSR random-sequence generator.
- Accepts one parallel LFSR state word per valid cycle.
- Self-synchronises a local predictor to the incoming stream, declares lock, then flywheels and counts mismatches.
- Sits at the sink of a generator-driven link, or in a self-test path, and reports link integrity.

---
 rtl/prbs_pkg.sv | 28 ++
 rtl/prbs_lfsr_step.sv | 29 ++
 rtl/prbs_sequence_checker.sv | 161 ++++++++++++++++
 tb/tb_prbs_sequence_checker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_pkg
//  Description : Shared definitions for the 4-bit Fibonacci LFSR generator and
//                checker: checker state enum, default taps/seed and the LFSR
//                step function.
//  Revision    : 1.0 - initial release
// ============================================================================
package prbs_pkg;

  localparam int              PRBS_W    = 4;
  localparam logic [PRBS_W-1:0] PRBS_TAPS = 4'b1100;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 4'b1011;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } prbs_state_e;

  // Shift left, feedback bit enters at the LSB.
  function automatic logic [PRBS_W-1:0] lfsr_next(input logic [PRBS_W-1:0] state,
                                                  input logic [PRBS_W-1:0] taps);
    return {state[PRBS_W-2:0], ^(state & taps)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_lfsr_step.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_lfsr_step
//  Description : Combinational LFSR step, o_next = next(i_state).
//  Ports       : i_state  in  WIDTH  current LFSR state
//                o_next   out WIDTH  successor state
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs_lfsr_step
  import prbs_pkg::*;
#(
  parameter int               WIDTH = PRBS_W,
  parameter logic [WIDTH-1:0] TAPS  = PRBS_TAPS
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  generate
    if (WIDTH == PRBS_W) begin : g_pkg_step
      // Same function the generator uses, so both ends cannot drift apart.
      assign o_next = lfsr_next(i_state, TAPS);
    end else begin : g_generic_step
      assign o_next = {i_state[WIDTH-2:0], ^(i_state & TAPS)};
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/prbs_sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module      : prbs_sequence_checker
//  Description : Receive-side checker for the Fibonacci LFSR sequence. Seeds a
//                local predictor from the stream, declares lock after
//                LOCK_COUNT correct predictions, then flywheels and counts
//                mismatches (saturating). UNLOCK_ERRS consecutive mismatches
//                drop lock.
//  Ports       : clk        in   rising-edge clock
//                rst_n      in   asynchronous active-low reset
//                in_valid   in   in_data carries a word this cycle
//                in_data    in   received LFSR state word
//                clr_cnt    in   synchronous clear of err_count
//                locked     out  predictor synchronised to the stream
//                err_pulse  out  previous valid word mismatched while locked
//                err_count  out  saturating mismatch count while locked
//  Revision    : 1.0 - initial release
// ============================================================================
module prbs_sequence_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH       = PRBS_W,
  parameter logic [WIDTH-1:0] TAPS        = PRBS_TAPS,
  parameter int               LOCK_COUNT  = 4,
  parameter int               UNLOCK_ERRS = 3,
  parameter int               ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [GOOD_W-1:0] c_lock_count  = GOOD_W'(LOCK_COUNT);
  localparam logic [BAD_W-1:0]  c_unlock_errs = BAD_W'(UNLOCK_ERRS);

  prbs_state_e            state_q, state_d;
  logic [WIDTH-1:0]       pred_q, pred_d;
  logic [GOOD_W-1:0]      good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]       bad_run_q, bad_run_d;
  logic                   locked_q, locked_d;
  logic                   err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  logic [WIDTH-1:0]       w_step_in;
  logic [WIDTH-1:0]       w_next;
  logic                   w_match;
  logic                   w_zero;
  logic [GOOD_W-1:0]      w_good_inc;
  logic [BAD_W-1:0]       w_bad_inc;

  // When the word matches the prediction, next(word) == next(pred), so the
  // single step instance only needs the predictor as input while flywheeling.
  assign w_step_in  = (state_q == LOCKED) ? pred_q : in_data;
  assign w_match    = (in_data == pred_q);
  assign w_zero     = (in_data == '0);
  assign w_good_inc = good_cnt_q + GOOD_W'(1);
  assign w_bad_inc  = bad_run_q + BAD_W'(1);

  prbs_lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .i_state (w_step_in),
    .o_next  (w_next)
  );

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    good_cnt_d  = good_cnt_q;
    bad_run_d   = bad_run_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          // All-zero is the LFSR lockup value and can never be a valid seed.
          if (!w_zero) begin
            pred_d     = w_next;
            good_cnt_d = '0;
            state_d    = LOCKING;
          end
        end
        LOCKING: begin
          if (w_match) begin
            pred_d     = w_next;
            good_cnt_d = w_good_inc;
            if (w_good_inc == c_lock_count) begin
              state_d   = LOCKED;
              bad_run_d = '0;
            end
          end else if (!w_zero) begin
            pred_d     = w_next;
            good_cnt_d = '0;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: never re-seed from data once locked.
          pred_d = w_next;
          if (w_match) begin
            bad_run_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            bad_run_d   = w_bad_inc;
            if (w_bad_inc == c_unlock_errs) begin
              state_d   = SEARCH;
              bad_run_d = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    // Clear has priority over an increment on the same cycle.
    if (clr_cnt) begin
      err_count_d = '0;
    end else if (err_pulse_d && !(&err_count_q)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      pred_q      <= '0;
      good_cnt_q  <= '0;
      bad_run_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      good_cnt_q  <= good_cnt_d;
      bad_run_q   <= bad_run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_prbs_sequence_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prbs_sequence_checker
//  Description : Self-checking bench for prbs_sequence_checker. Two DUTs share
//                one stimulus stream: the default configuration and a
//                narrow-counter / high-unlock configuration. A table-driven
//                reference model tracks position in the period-15 sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs_sequence_checker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       clr_cnt;

  logic        locked0, pulse0;
  logic [15:0] cnt0;
  logic        locked1, pulse1;
  logic [1:0]  cnt1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  prbs_sequence_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_cnt   (clr_cnt),
    .locked    (locked0),
    .err_pulse (pulse0),
    .err_count (cnt0)
  );

  prbs_sequence_checker #(
    .ERR_CNT_W   (2),
    .UNLOCK_ERRS (8)
  ) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_cnt   (clr_cnt),
    .locked    (locked1),
    .err_pulse (pulse1),
    .err_count (cnt1)
  );

  // Period-15 sequence for taps 1100, starting at the default seed.
  logic [3:0] tbl [15];

  int n_checks;
  int n_errors;
  int gi;

  // Reference model, one entry per configuration.
  // mode: 0 = hunting, 1 = confirming, 2 = synchronised
  int m_mode   [2];
  int m_idx    [2];   // table position of the predicted next word
  int m_good   [2];
  int m_bad    [2];
  int m_cnt    [2];
  bit m_pulse  [2];
  int m_unlock [2];
  int m_max    [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pos_of(input logic [3:0] w);
    for (int i = 0; i < 15; i++) if (tbl[i] == w) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_idx[k] = 0; m_good[k] = 0;
      m_bad[k]  = 0; m_cnt[k] = 0; m_pulse[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit v, input logic [3:0] d, input bit c);
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 1'b0;
      if (v) begin
        if (m_mode[k] == 0) begin
          if (d != 4'd0) begin
            m_idx[k] = (pos_of(d) + 1) % 15; m_good[k] = 0; m_mode[k] = 1;
          end
        end else if (m_mode[k] == 1) begin
          if (d == tbl[m_idx[k]]) begin
            m_idx[k] = (m_idx[k] + 1) % 15;
            m_good[k]++;
            if (m_good[k] == 4) begin m_mode[k] = 2; m_bad[k] = 0; end
          end else if (d != 4'd0) begin
            m_idx[k] = (pos_of(d) + 1) % 15; m_good[k] = 0;
          end else begin
            m_mode[k] = 0;
          end
        end else begin
          bit miss;
          miss     = (d != tbl[m_idx[k]]);
          m_idx[k] = (m_idx[k] + 1) % 15;
          if (miss) begin
            m_pulse[k] = 1'b1;
            if (m_cnt[k] < m_max[k]) m_cnt[k]++;
            m_bad[k]++;
            if (m_bad[k] == m_unlock[k]) begin m_mode[k] = 0; m_bad[k] = 0; end
          end else begin
            m_bad[k] = 0;
          end
        end
      end
      if (c) m_cnt[k] = 0;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".locked0"}, 32'(locked0), 32'(m_mode[0] == 2));
    chk({ctx, ".pulse0"},  32'(pulse0),  32'(m_pulse[0]));
    chk({ctx, ".cnt0"},    32'(cnt0),    32'(m_cnt[0]));
    chk({ctx, ".locked1"}, 32'(locked1), 32'(m_mode[1] == 2));
    chk({ctx, ".pulse1"},  32'(pulse1),  32'(m_pulse[1]));
    chk({ctx, ".cnt1"},    32'(cnt1),    32'(m_cnt[1]));
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input bit v, input logic [3:0] d, input bit c);
    in_valid = v;
    in_data  = d;
    clr_cnt  = c;
    @(posedge clk);
    model_step(v, d, c);
    @(negedge clk);
    check_all("cyc");
  endtask

  task automatic send_good();
    cycle(1'b1, tbl[gi], 1'b0);
    gi = (gi + 1) % 15;
  endtask

  task automatic send_bad(input logic [3:0] w, input bit c);
    cycle(1'b1, w, c);
    gi = (gi + 1) % 15;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'($urandom), 1'b0);
  endtask

  // Asserts reset between edges and checks outputs drop before any clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gi = 0;
  endtask

  initial begin
    tbl = '{4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001, 4'b0010,
            4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0101};
    m_unlock = '{3, 8};
    m_max    = '{65535, 3};
    n_checks = 0;
    n_errors = 0;
    gi       = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'd0;
    clr_cnt  = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Lock on the first five words.
    for (int i = 0; i < 5; i++) send_good();
    chk("lock.locked", 32'(locked0), 32'd1);
    chk("lock.cnt", 32'(cnt0), 32'd0);

    // Single error while locked: flywheel continues.
    send_bad(4'b1001, 1'b0);
    chk("single.pulse", 32'(pulse0), 32'd1);
    chk("single.cnt", 32'(cnt0), 32'd1);
    send_good();
    send_good();
    chk("single.still_locked", 32'(locked0), 32'd1);

    // Loss of lock after three consecutive errors, then relock.
    cycle(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) send_bad(4'b0000, 1'b0);
    chk("unlock.locked", 32'(locked0), 32'd0);
    chk("unlock.cnt", 32'(cnt0), 32'd3);
    chk("unlock.sat_locked", 32'(locked1), 32'd1);
    for (int i = 0; i < 5; i++) send_good();
    chk("relock.locked", 32'(locked0), 32'd1);
    chk("relock.cnt", 32'(cnt0), 32'd3);

    // Zero words in SEARCH, then lock with gaps between valid words.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0000, 1'b0);
    chk("zero.locked", 32'(locked0), 32'd0);
    for (int i = 0; i < 5; i++) begin
      send_good();
      if (i == 3) chk("gaps.not_yet", 32'(locked0), 32'd0);
      if (i == 4) chk("gaps.locked", 32'(locked0), 32'd1);
      idle(2);
    end

    // Saturation of the 2-bit counter and clear-versus-error priority.
    cycle(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) send_bad(~tbl[gi], 1'b0);
    chk("sat.cnt1", 32'(cnt1), 32'd3);
    chk("sat.locked1", 32'(locked1), 32'd1);
    send_bad(4'b0000, 1'b1);
    chk("clr.cnt1", 32'(cnt1), 32'd0);
    chk("clr.pulse1", 32'(pulse1), 32'd1);

    // Async reset mid-LOCKED; relock needs a full five-word run.
    do_reset();
    for (int i = 0; i < 5; i++) send_good();
    send_bad(4'b0000, 1'b0);
    chk("pre_rst.cnt", 32'(cnt0), 32'd1);
    do_reset();
    chk("post_rst.cnt", 32'(cnt0), 32'd0);
    for (int i = 0; i < 4; i++) send_good();
    chk("post_rst.not_yet", 32'(locked0), 32'd0);
    send_good();
    chk("post_rst.locked", 32'(locked0), 32'd1);

    // Randomised traffic: mostly clean stream with gaps, errors, zeros,
    // phase jumps, counter clears and occasional resets.
    for (int n = 0; n < 4000; n++) begin
      int r;
      bit c;
      r = $urandom_range(0, 999);
      c = ($urandom_range(0, 99) < 3);
      if (r < 3) begin
        do_reset();
      end else if (r < 150) begin
        cycle(1'b0, 4'($urandom), c);
      end else if (r < 250) begin
        send_bad(4'($urandom), c);
      end else if (r < 280) begin
        send_bad(4'b0000, c);
      end else if (r < 300) begin
        gi = $urandom_range(0, 14);
        cycle(1'b1, tbl[gi], c);
        gi = (gi + 1) % 15;
      end else begin
        cycle(1'b1, tbl[gi], c);
        gi = (gi + 1) % 15;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
